// File: rtl/inputcond_pkg.sv
// -----------------------------------------------------------------------------
// inputcond_pkg
// Shared definitions for the multi-channel input conditioner: default parameter
// values, the glitch counter width and a helper that returns the smallest
// debounce counter width able to hold WAIT_TIME-1.
// Optional feature macro used by the files that import this package:
//   INPUTCOND_GLITCH_COUNT_EN - adds per-channel saturating glitch counters.
// -----------------------------------------------------------------------------
package inputcond_pkg;

  // Smallest w such that 2**w > wait_time-1, with a floor of one bit.
  function automatic int min_cnt_width(input int wait_time);
    int w;
    w = 1;
    while ((32'd1 << w) < wait_time) w = w + 1;
    return w;
  endfunction

  localparam int DEF_NCHANNELS   = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_WAIT_TIME   = 3;
  localparam int DEF_CNT_WIDTH   = min_cnt_width(DEF_WAIT_TIME);
  localparam bit DEF_RESET_LEVEL = 1'b0;

  localparam int GLITCH_CNT_WIDTH = 8;

endpackage

// File: rtl/multi_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// multi_input_conditioner_if
// Bundles the per-channel data signals of the conditioner.
//   noisysignal   raw asynchronous inputs, one bit per channel
//   conditioned   debounced, synchronized levels
//   positiveedge  one-cycle pulse when a conditioned bit rises
//   negativeedge  one-cycle pulse when a conditioned bit falls
//   glitchclear   synchronous clear of all glitch counters (INPUTCOND_GLITCH_COUNT_EN)
//   glitchcount   8 bits per channel, channel i at [8i+7:8i] (INPUTCOND_GLITCH_COUNT_EN)
// master: the side that drives the raw inputs; slave: the conditioner itself.
// -----------------------------------------------------------------------------
interface multi_input_conditioner_if
  import inputcond_pkg::*;
#(
  parameter int NCHANNELS = DEF_NCHANNELS
);

  logic [NCHANNELS-1:0] noisysignal;
  logic [NCHANNELS-1:0] conditioned;
  logic [NCHANNELS-1:0] positiveedge;
  logic [NCHANNELS-1:0] negativeedge;

`ifdef INPUTCOND_GLITCH_COUNT_EN
  logic                                  glitchclear;
  logic [NCHANNELS*GLITCH_CNT_WIDTH-1:0] glitchcount;

  modport master (
    output noisysignal, glitchclear,
    input  conditioned, positiveedge, negativeedge, glitchcount
  );

  modport slave (
    input  noisysignal, glitchclear,
    output conditioned, positiveedge, negativeedge, glitchcount
  );
`else
  modport master (
    output noisysignal,
    input  conditioned, positiveedge, negativeedge
  );

  modport slave (
    input  noisysignal,
    output conditioned, positiveedge, negativeedge
  );
`endif

endinterface

// File: rtl/inputconditioner_channel.sv
// -----------------------------------------------------------------------------
// inputconditioner_channel
// One conditioner channel: SYNC_STAGES-deep synchronizer, debounce counter,
// registered edge pulses and (with INPUTCOND_GLITCH_COUNT_EN) a saturating
// glitch counter.
//   clk, reset_n        clock and asynchronous active-low reset
//   noisy_i             raw asynchronous input
//   conditioned_o       debounced level
//   rise_o / fall_o     one-cycle pulses on 0->1 / 1->0 of conditioned_o
//   glitch_clear_i      synchronous clear of the glitch counter (macro only)
//   glitch_count_o      saturating count of rejected disagreement runs (macro only)
// -----------------------------------------------------------------------------
module inputconditioner_channel
  import inputcond_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int WAIT_TIME   = DEF_WAIT_TIME,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter bit RESET_LEVEL = DEF_RESET_LEVEL
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        noisy_i,
`ifdef INPUTCOND_GLITCH_COUNT_EN
  input  logic                        glitch_clear_i,
  output logic [GLITCH_CNT_WIDTH-1:0] glitch_count_o,
`endif
  output logic                        conditioned_o,
  output logic                        rise_o,
  output logic                        fall_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WAIT_TIME - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   cond_q, cond_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Stage 0 may go metastable; only the last stage feeds the debouncer.
  assign sync_out = sync_q[SYNC_STAGES-1];

  // NOTE: state flops use non-blocking assignments and reset asynchronously,
  // so every register updates from pre-edge values regardless of order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q  <= '0;
      cond_q <= RESET_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_i};
      cnt_q  <= cnt_d;
      cond_q <= cond_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Any cycle of agreement restarts the run; the run is accepted on its
  // WAIT_TIME-th disagreeing cycle, which is also when the pulse is raised.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    cnt_d  = cnt_q;
    cond_d = cond_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_out == cond_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      cond_d = sync_out;
      rise_d = sync_out;
      fall_d = ~sync_out;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign conditioned_o = cond_q;
  assign rise_o        = rise_q;
  assign fall_o        = fall_q;

`ifdef INPUTCOND_GLITCH_COUNT_EN
  logic [GLITCH_CNT_WIDTH-1:0] glitch_q, glitch_d;
  logic                        glitch_hit;

  // A disagreement run that ends by agreement before acceptance is a glitch.
  assign glitch_hit = (cnt_q != '0) && (sync_out == cond_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) glitch_q <= '0;
    else          glitch_q <= glitch_d;
  end

  // Clear wins over a simultaneous increment; the count saturates at all-ones.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_clear_i)
      glitch_d = '0;
    else if (glitch_hit && (glitch_q != '1))
      glitch_d = glitch_q + 1'b1;
  end

  assign glitch_count_o = glitch_q;
`endif

endmodule

// File: rtl/multi_input_conditioner.sv
// -----------------------------------------------------------------------------
// multi_input_conditioner
// N independent input conditioner channels: synchronize, debounce and emit
// one-cycle edge pulses for board-level buttons and switches.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      multi_input_conditioner_if.slave:
//              noisysignal in, conditioned/positiveedge/negativeedge out,
//              glitchclear in / glitchcount out when INPUTCOND_GLITCH_COUNT_EN
//              is defined.
// The bus interface must be instantiated with the same NCHANNELS.
// -----------------------------------------------------------------------------
module multi_input_conditioner
  import inputcond_pkg::*;
#(
  parameter int NCHANNELS   = DEF_NCHANNELS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int WAIT_TIME   = DEF_WAIT_TIME,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter bit RESET_LEVEL = DEF_RESET_LEVEL
) (
  input  logic                      clk,
  input  logic                      reset_n,
  multi_input_conditioner_if.slave  bus
);

  logic [NCHANNELS-1:0] cond_w;
  logic [NCHANNELS-1:0] rise_w;
  logic [NCHANNELS-1:0] fall_w;
`ifdef INPUTCOND_GLITCH_COUNT_EN
  logic [NCHANNELS*GLITCH_CNT_WIDTH-1:0] glitch_w;
`endif

  for (genvar ch = 0; ch < NCHANNELS; ch++) begin : g_chan
    inputconditioner_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .WAIT_TIME   (WAIT_TIME),
      .CNT_WIDTH   (CNT_WIDTH),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .clk            (clk),
      .reset_n        (reset_n),
      .noisy_i        (bus.noisysignal[ch]),
`ifdef INPUTCOND_GLITCH_COUNT_EN
      .glitch_clear_i (bus.glitchclear),
      .glitch_count_o (glitch_w[ch*GLITCH_CNT_WIDTH +: GLITCH_CNT_WIDTH]),
`endif
      .conditioned_o  (cond_w[ch]),
      .rise_o         (rise_w[ch]),
      .fall_o         (fall_w[ch])
    );
  end

  assign bus.conditioned  = cond_w;
  assign bus.positiveedge = rise_w;
  assign bus.negativeedge = fall_w;
`ifdef INPUTCOND_GLITCH_COUNT_EN
  assign bus.glitchcount  = glitch_w;
`endif

endmodule

// File: tb/tb_multi_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_multi_input_conditioner
// dut0: RESET_LEVEL=0, dut1: RESET_LEVEL=1, both SYNC_STAGES=2, WAIT_TIME=3.
// Edge k of a scenario is the k-th rising clk edge after reset release (or
// after the scenario starts); expected outputs per edge are queued up front
// and popped as each edge is observed. Glitch scenario runs only with
// INPUTCOND_GLITCH_COUNT_EN defined.
// -----------------------------------------------------------------------------
module tb_multi_input_conditioner;
  import inputcond_pkg::*;

  localparam int N = 4;

  typedef struct {
    int         edge_no;
    logic [N-1:0] cond;
    logic [N-1:0] pos;
    logic [N-1:0] neg;
  } exp_t;

  logic clk;
  logic reset_n;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  multi_input_conditioner_if #(.NCHANNELS(N)) bus0 ();
  multi_input_conditioner_if #(.NCHANNELS(N)) bus1 ();

  multi_input_conditioner #(
    .NCHANNELS(N), .SYNC_STAGES(2), .WAIT_TIME(3), .CNT_WIDTH(2), .RESET_LEVEL(1'b0)
  ) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

  multi_input_conditioner #(
    .NCHANNELS(N), .SYNC_STAGES(2), .WAIT_TIME(3), .CNT_WIDTH(2), .RESET_LEVEL(1'b1)
  ) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply reset with dut0 inputs low and dut1 inputs as given; release on a
  // falling edge so the next rising edge is edge 1.
  task automatic do_reset(input logic [N-1:0] dut1_in);
    reset_n = 1'b0;
    bus0.noisysignal = '0;
    bus1.noisysignal = dut1_in;
`ifdef INPUTCOND_GLITCH_COUNT_EN
    bus0.glitchclear = 1'b0;
    bus1.glitchclear = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic push_exp(input int k, input logic [N-1:0] c,
                          input logic [N-1:0] p, input logic [N-1:0] n);
    exp_t e;
    e.edge_no = k; e.cond = c; e.pos = p; e.neg = n;
    exp_q.push_back(e);
  endtask

  // RESET_LEVEL=1 instance: falls to 0 normally, then async reset restores
  // 1111 without a clock edge, and steady-high inputs after release give no pulse.
  task automatic test_reset();
    exp_t e;
    do_reset('0);
    for (int k = 1; k <= 6; k++)
      push_exp(k, (k >= 5) ? 4'b0000 : 4'b1111, '0, (k == 5) ? 4'b1111 : 4'b0000);
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (bus1.conditioned !== e.cond || bus1.positiveedge !== e.pos || bus1.negativeedge !== e.neg) begin
        miscompares++;
        $display("FAIL reset_fall edge %0d: got cond=%b pos=%b neg=%b, want cond=%b pos=%b neg=%b",
                 e.edge_no, bus1.conditioned, bus1.positiveedge, bus1.negativeedge, e.cond, e.pos, e.neg);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus1.conditioned !== 4'b1111 || bus1.positiveedge !== 4'b0000 || bus1.negativeedge !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_async_lvl1: got cond=%b pos=%b neg=%b, want cond=1111 pos=0000 neg=0000",
               bus1.conditioned, bus1.positiveedge, bus1.negativeedge);
    end
    vectors++;
    if (bus0.conditioned !== 4'b0000 || bus0.positiveedge !== 4'b0000 || bus0.negativeedge !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_async_lvl0: got cond=%b pos=%b neg=%b, want cond=0000 pos=0000 neg=0000",
               bus0.conditioned, bus0.positiveedge, bus0.negativeedge);
    end
    bus1.noisysignal = '1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) push_exp(k, 4'b1111, '0, '0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (bus1.conditioned !== e.cond || bus1.positiveedge !== e.pos || bus1.negativeedge !== e.neg) begin
        miscompares++;
        $display("FAIL reset_release edge %0d: got cond=%b pos=%b neg=%b, want cond=%b pos=%b neg=%b",
                 e.edge_no, bus1.conditioned, bus1.positiveedge, bus1.negativeedge, e.cond, e.pos, e.neg);
      end
    end
  endtask

  // Channel 0 steps 0->1 before edge 1: rises with a pulse on edge 5 only.
  task automatic test_clean_step();
    exp_t e;
    do_reset('1);
    bus0.noisysignal[0] = 1'b1;
    for (int k = 1; k <= 8; k++)
      push_exp(k, (k >= 5) ? 4'b0001 : 4'b0000, (k == 5) ? 4'b0001 : 4'b0000, '0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (bus0.conditioned !== e.cond || bus0.positiveedge !== e.pos || bus0.negativeedge !== e.neg) begin
        miscompares++;
        $display("FAIL clean_step edge %0d: got cond=%b pos=%b neg=%b, want cond=%b pos=%b neg=%b",
                 e.edge_no, bus0.conditioned, bus0.positiveedge, bus0.negativeedge, e.cond, e.pos, e.neg);
      end
    end
  endtask

  // Channel 2 input: high, high, low, then high. sync_out is high on edges
  // 3-4, low on 5, high from 6, so the restarted run is accepted on edge 8.
  task automatic test_bounce();
    exp_t e;
    logic stim [1:4];
    stim[1] = 1'b1; stim[2] = 1'b1; stim[3] = 1'b0; stim[4] = 1'b1;
    do_reset('1);
    for (int k = 1; k <= 10; k++)
      push_exp(k, (k >= 8) ? 4'b0100 : 4'b0000, (k == 8) ? 4'b0100 : 4'b0000, '0);
    for (int k = 1; k <= 10; k++) begin
      bus0.noisysignal[2] = (k <= 4) ? stim[k] : 1'b1;
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (bus0.conditioned !== e.cond || bus0.positiveedge !== e.pos || bus0.negativeedge !== e.neg) begin
        miscompares++;
        $display("FAIL bounce edge %0d: got cond=%b pos=%b neg=%b, want cond=%b pos=%b neg=%b",
                 e.edge_no, bus0.conditioned, bus0.positiveedge, bus0.negativeedge, e.cond, e.pos, e.neg);
      end
    end
  endtask

  // Channel 0 high for three samples then low: rise on edge 5, fall on edge 8,
  // the minimum WAIT_TIME spacing between opposite pulses.
  task automatic test_back_to_back();
    exp_t e;
    do_reset('1);
    for (int k = 1; k <= 10; k++)
      push_exp(k, (k >= 5 && k <= 7) ? 4'b0001 : 4'b0000,
               (k == 5) ? 4'b0001 : 4'b0000, (k == 8) ? 4'b0001 : 4'b0000);
    for (int k = 1; k <= 10; k++) begin
      bus0.noisysignal[0] = (k <= 3);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (bus0.conditioned !== e.cond || bus0.positiveedge !== e.pos || bus0.negativeedge !== e.neg) begin
        miscompares++;
        $display("FAIL back_to_back edge %0d: got cond=%b pos=%b neg=%b, want cond=%b pos=%b neg=%b",
                 e.edge_no, bus0.conditioned, bus0.positiveedge, bus0.negativeedge, e.cond, e.pos, e.neg);
      end
    end
  endtask

  // Channel 3 rises first; then channel 1 rises and channel 3 falls together,
  // giving pos=0010 and neg=1000 on the same edge (11).
  task automatic test_simultaneous();
    exp_t e;
    do_reset('1);
    for (int k = 1; k <= 12; k++)
      push_exp(k, (k >= 11) ? 4'b0010 : (k >= 5) ? 4'b1000 : 4'b0000,
               (k == 5) ? 4'b1000 : (k == 11) ? 4'b0010 : 4'b0000,
               (k == 11) ? 4'b1000 : 4'b0000);
    for (int k = 1; k <= 12; k++) begin
      bus0.noisysignal = (k <= 6) ? 4'b1000 : 4'b0010;
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (bus0.conditioned !== e.cond || bus0.positiveedge !== e.pos || bus0.negativeedge !== e.neg) begin
        miscompares++;
        $display("FAIL simultaneous edge %0d: got cond=%b pos=%b neg=%b, want cond=%b pos=%b neg=%b",
                 e.edge_no, bus0.conditioned, bus0.positiveedge, bus0.negativeedge, e.cond, e.pos, e.neg);
      end
    end
  endtask

  // Channel 1 counter reaches 2 on edge 4; reset then discards it and the
  // held-high input needs the full 5 edges again after release.
  task automatic test_reset_mid();
    exp_t e;
    do_reset('1);
    bus0.noisysignal[1] = 1'b1;
    for (int k = 1; k <= 4; k++) push_exp(k, '0, '0, '0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (bus0.conditioned !== e.cond || bus0.positiveedge !== e.pos || bus0.negativeedge !== e.neg) begin
        miscompares++;
        $display("FAIL reset_mid_pre edge %0d: got cond=%b pos=%b neg=%b, want cond=%b pos=%b neg=%b",
                 e.edge_no, bus0.conditioned, bus0.positiveedge, bus0.negativeedge, e.cond, e.pos, e.neg);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus0.conditioned !== 4'b0000 || bus0.positiveedge !== 4'b0000 || bus0.negativeedge !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_mid_async: got cond=%b pos=%b neg=%b, want cond=0000 pos=0000 neg=0000",
               bus0.conditioned, bus0.positiveedge, bus0.negativeedge);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++)
      push_exp(k, (k >= 5) ? 4'b0010 : 4'b0000, (k == 5) ? 4'b0010 : 4'b0000, '0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (bus0.conditioned !== e.cond || bus0.positiveedge !== e.pos || bus0.negativeedge !== e.neg) begin
        miscompares++;
        $display("FAIL reset_mid_post edge %0d: got cond=%b pos=%b neg=%b, want cond=%b pos=%b neg=%b",
                 e.edge_no, bus0.conditioned, bus0.positiveedge, bus0.negativeedge, e.cond, e.pos, e.neg);
      end
    end
  endtask

`ifdef INPUTCOND_GLITCH_COUNT_EN
  // One-cycle pulses on channel 0: each increments its glitch counter two
  // edges after the high sample reaches sync_out; conditioned never moves.
  task automatic test_glitch_count();
    int gexp_q[$];
    int want;
    do_reset('1);
    for (int g = 0; g < 10; g++) begin
      bus0.noisysignal[0] = 1'b1; tick();
      bus0.noisysignal[0] = 1'b0; tick();
    end
    gexp_q.push_back(10);
    repeat (3) tick();
    want = gexp_q.pop_front();
    vectors++;
    if (bus0.glitchcount[7:0] !== 8'(want) || bus0.conditioned !== 4'b0000) begin
      miscompares++;
      $display("FAIL glitch_10: got count=%0d cond=%b, want count=%0d cond=0000",
               bus0.glitchcount[7:0], bus0.conditioned, want);
    end
    for (int g = 10; g < 300; g++) begin
      bus0.noisysignal[0] = 1'b1; tick();
      bus0.noisysignal[0] = 1'b0; tick();
    end
    gexp_q.push_back(255);
    repeat (3) tick();
    want = gexp_q.pop_front();
    vectors++;
    if (bus0.glitchcount !== {24'd0, 8'(want)}) begin
      miscompares++;
      $display("FAIL glitch_saturate: got counts=%h, want counts=%h",
               bus0.glitchcount, {24'd0, 8'(want)});
    end
    // Clear exactly on the edge that would increment.
    bus0.noisysignal[0] = 1'b1; tick();
    bus0.noisysignal[0] = 1'b0; tick();
    tick();
    bus0.glitchclear = 1'b1;
    gexp_q.push_back(0);
    tick();
    bus0.glitchclear = 1'b0;
    repeat (2) tick();
    want = gexp_q.pop_front();
    vectors++;
    if (bus0.glitchcount[7:0] !== 8'(want)) begin
      miscompares++;
      $display("FAIL glitch_clear: got count=%0d, want count=%0d", bus0.glitchcount[7:0], want);
    end
    bus0.noisysignal[0] = 1'b1; tick();
    bus0.noisysignal[0] = 1'b0; tick();
    gexp_q.push_back(1);
    repeat (3) tick();
    want = gexp_q.pop_front();
    vectors++;
    if (bus0.glitchcount[7:0] !== 8'(want)) begin
      miscompares++;
      $display("FAIL glitch_after_clear: got count=%0d, want count=%0d", bus0.glitchcount[7:0], want);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b1;
    bus0.noisysignal = '0;
    bus1.noisysignal = '0;
`ifdef INPUTCOND_GLITCH_COUNT_EN
    bus0.glitchclear = 1'b0;
    bus1.glitchclear = 1'b0;
`endif
    #1;
    test_reset();
    test_clean_step();
    test_bounce();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
`ifdef INPUTCOND_GLITCH_COUNT_EN
    test_glitch_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
